// File: rtl/pwm_capture_mc.sv
// pwm_capture_mc
//
// Multi-channel PWM capture. Each channel input is synchronised, then sampled
// once per enabled clock across a measurement window of period+1 samples.
// During the window, two things are counted for every channel: the number of
// samples where the input was high (duty) and the number of rising edges
// (edges). At the end of the window both counts are published, together with
// a saturation flag, and valid is pulsed for one cycle.
//
// Ports
//   clk     : single clock, rising edge
//   rst     : synchronous active-high reset
//   en      : sample enable; when low, window and channel state hold
//   in      : CH asynchronous PWM inputs, bit k = channel k
//   period  : period for the next window (window length = period+1)
//   duty    : per-channel high-sample count of the last window, ch k at [k*N +: N]
//   edges   : per-channel rising-edge count of the last window, same packing
//   sat     : per-channel flag, a count saturated in the last window
//   valid   : one-cycle strobe when duty/edges/sat are updated

module pwm_capture_mc #(
    parameter int N          = 8,
    parameter int CH         = 4,
    parameter int DEF_PERIOD = 2**N - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CH-1:0]   in,
    input  logic [N-1:0]    period,
    output logic [CH*N-1:0] duty,
    output logic [CH*N-1:0] edges,
    output logic [CH-1:0]   sat,
    output logic            valid
);

    localparam logic [N-1:0] MAXV = '1;

    logic [CH-1:0] sync1;
    logic [CH-1:0] s;
    logic [CH-1:0] p;
    logic [CH-1:0] ovf;
    logic [CH-1:0] rise;
    logic [N-1:0]  wcnt;
    logic [N-1:0]  pq;
    logic [N-1:0]  hacc [CH];
    logic [N-1:0]  eacc [CH];
    logic          term;

    // p only advances on enabled cycles, so a pause never creates or hides an edge
    assign rise = s & ~p;
    assign term = (wcnt == pq);

    // Saturating increment: at all-ones, a further increment is dropped
    function automatic logic [N-1:0] sat_inc(input logic [N-1:0] a, input logic b);
        return (b && (a != MAXV)) ? a + N'(1) : a;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            s     <= '0;
            p     <= '0;
            ovf   <= '0;
            wcnt  <= '0;
            pq    <= N'(DEF_PERIOD);
            duty  <= '0;
            edges <= '0;
            sat   <= '0;
            valid <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                hacc[k] <= '0;
                eacc[k] <= '0;
            end
        end else begin
            // Synchronisers run regardless of en
            sync1 <= in;
            s     <= sync1;
            valid <= 1'b0;

            if (en) begin
                p <= s;
                if (term) begin
                    // Terminal cycle: fold in this last sample, publish, restart
                    wcnt  <= '0;
                    pq    <= period;
                    valid <= 1'b1;
                    for (int k = 0; k < CH; k++) begin
                        duty[k*N +: N]  <= sat_inc(hacc[k], s[k]);
                        edges[k*N +: N] <= sat_inc(eacc[k], rise[k]);
                        sat[k]          <= ovf[k]
                                           | (s[k] && (hacc[k] == MAXV))
                                           | (rise[k] && (eacc[k] == MAXV));
                        hacc[k]         <= '0;
                        eacc[k]         <= '0;
                    end
                    ovf <= '0;
                end else begin
                    wcnt <= wcnt + N'(1);
                    for (int k = 0; k < CH; k++) begin
                        hacc[k] <= sat_inc(hacc[k], s[k]);
                        eacc[k] <= sat_inc(eacc[k], rise[k]);
                        // Sticky: any dropped increment in the window marks it saturated
                        ovf[k]  <= ovf[k]
                                   | (s[k] && (hacc[k] == MAXV))
                                   | (rise[k] && (eacc[k] == MAXV));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture_mc.sv
// tb_pwm_capture_mc
//
// Bench for pwm_capture_mc (N=8, CH=4). A directed vector table, hand-written
// sequences for the multi-cycle window behaviour, and a randomized run; a
// reference model of windowed counting is compared against the DUT every cycle.

module tb_pwm_capture_mc;

    localparam int N   = 8;
    localparam int CH  = 4;
    localparam int DEF = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [CH-1:0]   in;
    logic [N-1:0]    period;
    logic [CH*N-1:0] duty;
    logic [CH*N-1:0] edges;
    logic [CH-1:0]   sat;
    logic            valid;

    pwm_capture_mc #(.N(N), .CH(CH), .DEF_PERIOD(DEF)) dut (
        .clk(clk), .rst(rst), .en(en), .in(in), .period(period),
        .duty(duty), .edges(edges), .sat(sat), .valid(valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: integer counts per window, clamped when published
    logic [CH-1:0]   ms1, ms2, mp;
    int              mcnt, mpq;
    int              hcnt [CH];
    int              ecnt [CH];
    logic [CH*N-1:0] mduty, medges;
    logic [CH-1:0]   msat;
    logic            mvalid;

    // Wave generator state for the directed sequences
    int              tick = 0;
    logic            wave_rst = 1'b0;
    logic            wave_en = 1'b1;
    logic [N-1:0]    wave_period = 8'd255;

    typedef struct {
        logic            rst;
        logic            en;
        logic [CH-1:0]   in;
        logic [N-1:0]    period;
        int              reps;
        logic            exp_valid;
        logic [CH*N-1:0] exp_duty;
        logic [CH*N-1:0] exp_edges;
        logic [CH-1:0]   exp_sat;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [N-1:0] clamp(input int x);
        logic [31:0] v;
        v = x;
        return (x > 255) ? 8'd255 : v[7:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelStep();
        logic [CH-1:0] smp;
        if (rst) begin
            ms1 = '0; ms2 = '0; mp = '0;
            mcnt = 0; mpq = DEF;
            for (int k = 0; k < CH; k++) begin
                hcnt[k] = 0;
                ecnt[k] = 0;
            end
            mduty = '0; medges = '0; msat = '0; mvalid = 1'b0;
        end else begin
            smp    = ms2;
            mvalid = 1'b0;
            if (en) begin
                for (int k = 0; k < CH; k++) begin
                    hcnt[k] += int'(smp[k]);
                    ecnt[k] += int'(smp[k] & ~mp[k]);
                end
                mp = smp;
                if (mcnt == mpq) begin
                    for (int k = 0; k < CH; k++) begin
                        mduty[k*N +: N]  = clamp(hcnt[k]);
                        medges[k*N +: N] = clamp(ecnt[k]);
                        msat[k]          = (hcnt[k] > 255) || (ecnt[k] > 255);
                        hcnt[k] = 0;
                        ecnt[k] = 0;
                    end
                    mvalid = 1'b1;
                    mcnt   = 0;
                    mpq    = int'(period);
                end else begin
                    mcnt++;
                end
            end
            ms2 = ms1;
            ms1 = in;
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare at the negedge
    task automatic applyStimulus(input logic r, input logic e, input logic [CH-1:0] i, input logic [N-1:0] per);
        rst    = r;
        en     = e;
        in     = i;
        period = per;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("model_valid", 32'(valid), 32'(mvalid));
        checkOutput("model_duty",  duty,  mduty);
        checkOutput("model_edges", edges, medges);
        checkOutput("model_sat",   32'(sat), 32'(msat));
    endtask

    // ch0: 25% square wave of period 20, ch1 held high, ch2 held low, ch3 noise
    task automatic stepWave();
        logic [CH-1:0] v;
        v[0] = ((tick % 20) < 5);
        v[1] = 1'b1;
        v[2] = 1'b0;
        v[3] = 1'($urandom);
        tick++;
        applyStimulus(wave_rst, wave_en, v, wave_period);
    endtask

    task automatic runSteps(input int n);
        for (int i = 0; i < n; i++) stepWave();
    endtask

    task automatic runUntilValid(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            stepWave();
            cycles++;
            if (valid === 1'b1) break;
        end
        if (valid !== 1'b1) begin
            checks++;
            fails++;
            $display("[TB] FAIL valid_timeout: got no valid, expected one within %0d cycles", budget);
        end
    endtask

    int cyc;

    initial begin
        rst = 1'b1; en = 1'b0; in = '0; period = '0;
        ms1 = '0; ms2 = '0; mp = '0; mcnt = 0; mpq = DEF;
        mduty = '0; medges = '0; msat = '0; mvalid = 1'b0;
        for (int k = 0; k < CH; k++) begin
            hcnt[k] = 0;
            ecnt[k] = 0;
        end

        // Directed table: s lags in by two samples, so the first window after
        // reset with ch1 high sees 254 high samples and one rising edge
        tbl[0] = '{1'b1, 1'b0, 4'h0, 8'd0, 2,   1'b0, 32'h0,        32'h0,        4'h0};
        tbl[1] = '{1'b0, 1'b1, 4'h2, 8'd0, 255, 1'b0, 32'h0,        32'h0,        4'h0};
        tbl[2] = '{1'b0, 1'b1, 4'h2, 8'd0, 1,   1'b1, 32'h0000FE00, 32'h00000100, 4'h0};
        tbl[3] = '{1'b0, 1'b1, 4'h2, 8'd0, 1,   1'b1, 32'h00000100, 32'h0,        4'h0};
        tbl[4] = '{1'b0, 1'b0, 4'h2, 8'd0, 1,   1'b0, 32'h00000100, 32'h0,        4'h0};
        tbl[5] = '{1'b0, 1'b1, 4'h0, 8'd0, 3,   1'b1, 32'h0,        32'h0,        4'h0};
        tbl[6] = '{1'b0, 1'b1, 4'h1, 8'd0, 3,   1'b1, 32'h00000001, 32'h00000001, 4'h0};
        tbl[7] = '{1'b1, 1'b1, 4'h1, 8'd0, 1,   1'b0, 32'h0,        32'h0,        4'h0};

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < tbl[i].reps; r++)
                applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].in, tbl[i].period);
            checkOutput($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].exp_valid));
            checkOutput($sformatf("tbl%0d_duty", i),  duty,  tbl[i].exp_duty);
            checkOutput($sformatf("tbl%0d_edges", i), edges, tbl[i].exp_edges);
            checkOutput($sformatf("tbl%0d_sat", i),   32'(sat), 32'(tbl[i].exp_sat));
        end

        // Held-high channel over full 256-sample windows saturates; held-low stays 0
        wave_period = 8'd255;
        runUntilValid(400, cyc);
        checkOutput("first_window_len", 32'(cyc), 32'd256);
        runUntilValid(400, cyc);
        checkOutput("second_window_len", 32'(cyc), 32'd256);
        checkOutput("held_hi_duty",  32'(duty[15:8]),  32'd255);
        checkOutput("held_hi_sat",   32'(sat[1]),      32'd1);
        checkOutput("held_hi_edges", 32'(edges[15:8]), 32'd0);
        checkOutput("held_lo_duty",  32'(duty[23:16]), 32'd0);
        checkOutput("held_lo_edges", 32'(edges[23:16]), 32'd0);
        checkOutput("held_lo_sat",   32'(sat[2]),      32'd0);

        // Period 99: square wave gives 25 high samples and 5 edges per window
        wave_period = 8'd99;
        runUntilValid(400, cyc);
        runUntilValid(400, cyc);
        checkOutput("p99_window_len", 32'(cyc), 32'd100);
        checkOutput("sq_duty",  32'(duty[7:0]),  32'd25);
        checkOutput("sq_edges", 32'(edges[7:0]), 32'd5);
        checkOutput("sq_sat",   32'(sat[0]),     32'd0);
        checkOutput("hi_duty100", 32'(duty[15:8]), 32'd100);
        checkOutput("hi_sat100",  32'(sat[1]),     32'd0);

        // Period change mid-window only affects the following window
        runSteps(30);
        wave_period = 8'd49;
        runUntilValid(400, cyc);
        checkOutput("midchange_rest", 32'(cyc), 32'd70);
        checkOutput("midchange_duty", 32'(duty[7:0]), 32'd25);
        runUntilValid(400, cyc);
        checkOutput("p49_window_len", 32'(cyc), 32'd50);
        checkOutput("hi_duty50", 32'(duty[15:8]), 32'd50);

        // Back to 100-sample windows (one more 50 window already latched)
        wave_period = 8'd99;
        runUntilValid(400, cyc);
        checkOutput("p49_again_len", 32'(cyc), 32'd50);
        runUntilValid(400, cyc);
        checkOutput("p99_again_len", 32'(cyc), 32'd100);

        // 30-cycle en pause mid-window delays valid by exactly 30
        runSteps(40);
        wave_en = 1'b0;
        runSteps(30);
        wave_en = 1'b1;
        runUntilValid(400, cyc);
        checkOutput("pause_total_len", 32'(40 + 30 + cyc), 32'd130);
        checkOutput("pause_hi_duty",  32'(duty[15:8]),  32'd100);
        checkOutput("pause_hi_edges", 32'(edges[15:8]), 32'd0);
        checkOutput("pause_lo_duty",  32'(duty[23:16]), 32'd0);

        // Reset at wcnt=60 (with en high) discards the window
        runSteps(60);
        wave_rst = 1'b1;
        stepWave();
        wave_rst = 1'b0;
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_duty",  duty,  32'd0);
        checkOutput("rst_edges", edges, 32'd0);
        checkOutput("rst_sat",   32'(sat), 32'd0);
        // DEF+1 = 256 samples counted from the first cycle after reset
        runUntilValid(400, cyc);
        checkOutput("post_rst_len", 32'(cyc), 32'd256);
        checkOutput("post_rst_hi_duty",  32'(duty[15:8]),  32'd254);
        checkOutput("post_rst_hi_edges", 32'(edges[15:8]), 32'd1);
        checkOutput("post_rst_hi_sat",   32'(sat[1]),      32'd0);

        // Randomized run against the model, including pq=0 and reset collisions
        for (int i = 0; i < 4000; i++) begin
            logic [N-1:0] per;
            per = ($urandom_range(0, 9) == 0) ? N'($urandom) : N'($urandom_range(0, 5));
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0),
                          CH'($urandom), per);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
